// File: rtl/csr_exec.sv
// rtl/csr_exec.sv - Zicsr executor: read, modify, conditional write of one CSR per instruction.
// Optional privilege check on the CSR address is enabled by defining CSR_PRIV_CHECK_EN.
module csr_exec #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [CSR_AW-1:0] csr_addr_in,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [4:0]        rs1_idx,
  input  logic [4:0]        rd_idx,
  input  logic [1:0]        priv,
  output logic [CSR_AW-1:0] csr_addr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              csr_we,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              busy,
  output logic              done,
  output logic              rd_we,
  output logic [XLEN-1:0]   rd_data,
  output logic              illegal
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_rs1_val;
  logic [4:0]      r_rs1_idx;
  logic [4:0]      r_rd_idx;
  logic [XLEN-1:0] r_old;
  logic            r_illegal;
  logic            r_csr_we;

  logic [XLEN-1:0] w_src;
  logic [XLEN-1:0] w_new;
  logic            w_do_write;
  logic            w_bad_op;
  logic            w_read_only;
  logic            w_priv_fault;
  logic            w_illegal;

  // The write strobe is gated by reset so an abort in WRITE never reaches the CSR file.
  assign csr_we = r_csr_we & resetn;

`ifdef CSR_PRIV_CHECK_EN
  logic [1:0] r_priv;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_priv <= 2'b00;
    end else if (r_state == S_IDLE && start) begin
      r_priv <= priv;
    end
  end

  assign w_priv_fault = (csr_addr[CSR_AW-3 -: 2] > r_priv);
`else
  logic w_unused_priv;
  assign w_unused_priv = ^priv;
  assign w_priv_fault  = 1'b0;
`endif

  always_comb begin
    w_src       = r_funct3[2] ? {{(XLEN-5){1'b0}}, r_rs1_idx} : r_rs1_val;
    w_bad_op    = (r_funct3[1:0] == 2'b00);
    w_do_write  = (r_funct3[1:0] == 2'b01) || (r_rs1_idx != 5'd0);
    w_read_only = (csr_addr[CSR_AW-1 -: 2] == 2'b11);
    w_illegal   = w_bad_op || (w_read_only && w_do_write) || w_priv_fault;
    case (r_funct3[1:0])
      2'b01:   w_new = w_src;
      2'b10:   w_new = csr_rdata | w_src;
      2'b11:   w_new = csr_rdata & ~w_src;
      default: w_new = csr_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_funct3  <= 3'b000;
      r_rs1_val <= '0;
      r_rs1_idx <= 5'd0;
      r_rd_idx  <= 5'd0;
      r_old     <= '0;
      r_illegal <= 1'b0;
      r_csr_we  <= 1'b0;
      csr_addr  <= '0;
      csr_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_we     <= 1'b0;
      rd_data   <= '0;
      illegal   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_funct3  <= funct3;
            r_rs1_val <= rs1_val;
            r_rs1_idx <= rs1_idx;
            r_rd_idx  <= rd_idx;
            csr_addr  <= csr_addr_in;
            busy      <= 1'b1;
            r_state   <= S_READ;
          end
        end
        S_READ: begin
          r_old     <= csr_rdata;
          r_illegal <= w_illegal;
          r_csr_we  <= w_do_write && !w_illegal;
          csr_wdata <= w_new;
          r_state   <= S_WRITE;
        end
        S_WRITE: begin
          r_csr_we  <= 1'b0;
          csr_wdata <= '0;
          done      <= 1'b1;
          rd_we     <= !r_illegal && (r_rd_idx != 5'd0);
          rd_data   <= r_old;
          illegal   <= r_illegal;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          done      <= 1'b0;
          rd_we     <= 1'b0;
          rd_data   <= '0;
          illegal   <= 1'b0;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
